// File: rtl/ifu_fetch.sv
// Instruction fetch front end: issues word reads on a req/gnt/rvalid bus and
// buffers returned {pc,inst} pairs in an in-order queue presented to decode.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        jump_req_i,
  input  logic [31:0] jump_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
  logic [PW-1:0] fl_rd_q, fl_rd_d, fl_wr_q, fl_wr_d;
  logic [31:0]   q_pc_q   [QDEPTH];
  logic [31:0]   q_inst_q [QDEPTH];
  logic [31:0]   fl_pc_q  [QDEPTH];

  logic fire, rsp, drop, redirect, pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == QDEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Credit covers both buffered and in-flight words, so the queue cannot overflow.
  always_comb begin
    ibus_req_o   = rst_n && ((int'(count_q) + int'(outst_q)) < QDEPTH);
    ibus_addr_o  = fetch_pc_q;
    inst_valid_o = (count_q != '0);
    pc_o         = inst_valid_o ? q_pc_q[q_rd_q] : 32'h0;
    inst_o       = inst_valid_o ? q_inst_q[q_rd_q] : NOP_INST;
  end

  always_comb begin
    fire     = ibus_req_o & ibus_gnt_i;
    rsp      = ibus_rvalid_i & (outst_q != '0);
    drop     = rsp & (discard_q != '0);
    redirect = jump_req_i & ~stall_i;
    pop      = inst_valid_o & ~stall_i;
    push     = rsp & ~drop & ~redirect;

    outst_d = outst_q;
    if (fire && !rsp)      outst_d = outst_q + CW'(1);
    else if (!fire && rsp) outst_d = outst_q - CW'(1);

    // Everything still in flight after a redirect edge belongs to the old path.
    discard_d = discard_q;
    if (redirect)  discard_d = outst_d;
    else if (drop) discard_d = discard_q - CW'(1);

    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = {jump_pc_i[31:2], 2'b00};
    else if (fire) fetch_pc_d = fetch_pc_q + 32'd4;

    fl_wr_d = fire ? ptr_inc(fl_wr_q) : fl_wr_q;
    fl_rd_d = rsp  ? ptr_inc(fl_rd_q) : fl_rd_q;

    count_d = count_q;
    q_rd_d  = q_rd_q;
    q_wr_d  = q_wr_q;
    if (redirect) begin
      count_d = '0;
      q_rd_d  = '0;
      q_wr_d  = '0;
    end else begin
      if (pop)  q_rd_d = ptr_inc(q_rd_q);
      if (push) q_wr_d = ptr_inc(q_wr_q);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      fl_rd_q    <= '0;
      fl_wr_q    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_q[i]   <= '0;
        q_inst_q[i] <= '0;
        fl_pc_q[i]  <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      fl_rd_q    <= fl_rd_d;
      fl_wr_q    <= fl_wr_d;
      if (fire) fl_pc_q[fl_wr_q] <= fetch_pc_q;
      if (push) begin
        q_pc_q[q_wr_q]   <= fl_pc_q[fl_rd_q];
        q_inst_q[q_wr_q] <= ibus_rdata_i;
      end
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: bus responder plus an in-order scoreboard of expected
// {pc,inst} pairs, and one task per scenario with its own direct checks.
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        jump_req_i = 1'b0;
  logic [31:0] jump_pc_i = 32'h0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_checks = 0;
  int n_pass = 0;
  int delivered = 0;

  logic        rsp_hold = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] infl_pc[$];
  logic        infl_stale[$];
  logic [31:0] bus_pend[$];
  logic [31:0] model_pc = RESET_PC;
  logic        nxt_rvalid = 1'b0;
  logic [31:0] nxt_rdata = 32'h0;

  ifu_fetch #(.RESET_PC(RESET_PC), .QDEPTH(2), .NOP_INST(NOP_INST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .jump_req_i   (jump_req_i),
    .jump_pc_i    (jump_pc_i),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  // Bus responder output: data for a grant appears one cycle after it.
  always @(posedge clk) begin
    #1;
    ibus_rvalid_i = rst_n & nxt_rvalid;
    ibus_rdata_i  = nxt_rdata;
  end

  // Scoreboard: compares the head, then models what the coming edge does.
  always @(negedge clk) begin : mon
    logic        redirect, fire, st;
    logic [31:0] a;
    if (!rst_n) begin
      exp_q.delete();
      infl_pc.delete();
      infl_stale.delete();
      bus_pend.delete();
      model_pc   = RESET_PC;
      nxt_rvalid = 1'b0;
    end else begin
      n_checks++;
      if (exp_q.size() == 0) begin
        if (inst_valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== NOP_INST)
          $display("FAIL sb_empty: got valid=%0b pc=%h inst=%h, expected valid=0 pc=0 inst=%h",
                   inst_valid_o, pc_o, inst_o, NOP_INST);
        else n_pass++;
      end else begin
        if (inst_valid_o !== 1'b1 || pc_o !== exp_q[0] || inst_o !== word_of(exp_q[0]))
          $display("FAIL sb_head: got valid=%0b pc=%h inst=%h, expected valid=1 pc=%h inst=%h",
                   inst_valid_o, pc_o, inst_o, exp_q[0], word_of(exp_q[0]));
        else n_pass++;
      end

      redirect = jump_req_i & ~stall_i;
      fire     = ibus_req_o & ibus_gnt_i;
      if (inst_valid_o === 1'b1 && !stall_i) delivered++;

      if (redirect) begin
        exp_q.delete();
        foreach (infl_stale[i]) infl_stale[i] = 1'b1;
      end else if (inst_valid_o === 1'b1 && !stall_i && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end

      if (ibus_rvalid_i && infl_pc.size() > 0) begin
        a  = infl_pc.pop_front();
        st = infl_stale.pop_front();
        if (!st && !redirect) exp_q.push_back(a);
      end

      if (fire) begin
        n_checks++;
        if (ibus_addr_o !== model_pc)
          $display("FAIL grant_addr: got %h, expected %h", ibus_addr_o, model_pc);
        else n_pass++;
        infl_pc.push_back(model_pc);
        infl_stale.push_back(redirect);
        bus_pend.push_back(ibus_addr_o);
        model_pc = model_pc + 32'd4;
      end
      if (redirect) model_pc = {jump_pc_i[31:2], 2'b00};

      if (!rsp_hold && bus_pend.size() > 0) begin
        nxt_rvalid = 1'b1;
        nxt_rdata  = word_of(bus_pend.pop_front());
      end else begin
        nxt_rvalid = 1'b0;
        nxt_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    ibus_gnt_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ibus_req_o !== 1'b0) $display("FAIL reset_req: got %0b, expected 0", ibus_req_o);
    else n_pass++;
    n_checks++;
    if (ibus_addr_o !== RESET_PC) $display("FAIL reset_addr: got %h, expected %h", ibus_addr_o, RESET_PC);
    else n_pass++;
    n_checks++;
    if (inst_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b, expected 0", inst_valid_o);
    else n_pass++;
    n_checks++;
    if (inst_o !== NOP_INST) $display("FAIL reset_inst: got %h, expected %h", inst_o, NOP_INST);
    else n_pass++;
    n_checks++;
    if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h, expected 0", pc_o);
    else n_pass++;
  endtask

  task automatic test_fetch_seq();
    int d0;
    ibus_gnt_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== RESET_PC || inst_valid_o !== 1'b0)
      $display("FAIL first_req: got req=%0b addr=%h valid=%0b, expected req=1 addr=%h valid=0",
               ibus_req_o, ibus_addr_o, inst_valid_o, RESET_PC);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ibus_addr_o !== RESET_PC + 32'd4 || inst_valid_o !== 1'b0)
      $display("FAIL second_req: got addr=%h valid=%0b, expected addr=%h valid=0",
               ibus_addr_o, inst_valid_o, RESET_PC + 32'd4);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b1 || pc_o !== RESET_PC || inst_o !== word_of(RESET_PC))
      $display("FAIL first_valid: got valid=%0b pc=%h inst=%h, expected valid=1 pc=%h inst=%h",
               inst_valid_o, pc_o, inst_o, RESET_PC, word_of(RESET_PC));
    else n_pass++;
    @(posedge clk);
    d0 = delivered;
    repeat (21) @(posedge clk);
    n_checks++;
    if (delivered - d0 < 10)
      $display("FAIL throughput: got %0d instructions in 21 cycles, expected at least 10", delivered - d0);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] cap;
    @(posedge clk); #1;
    stall_i = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    cap = (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (inst_valid_o !== 1'b1 || pc_o !== cap || inst_o !== word_of(cap) || ibus_req_o !== 1'b0)
        $display("FAIL stall_hold: got valid=%0b pc=%h inst=%h req=%0b, expected valid=1 pc=%h inst=%h req=0",
                 inst_valid_o, pc_o, inst_o, ibus_req_o, cap, word_of(cap));
      else n_pass++;
    end
    @(posedge clk); #1;
    stall_i = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_jump();
    bit found;
    @(posedge clk); #1;
    rsp_hold = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b0 || ibus_req_o !== 1'b0)
      $display("FAIL two_in_flight: got valid=%0b req=%0b, expected valid=0 req=0", inst_valid_o, ibus_req_o);
    else n_pass++;
    @(posedge clk); #1;
    jump_req_i = 1'b1;
    jump_pc_i  = 32'h0000_0100;
    rsp_hold   = 1'b0;
    @(posedge clk); #1;
    jump_req_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (ibus_req_o === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || ibus_addr_o !== 32'h0000_0100)
      $display("FAIL jump_addr: got found=%0b addr=%h, expected found=1 addr=00000100", found, ibus_addr_o);
    else n_pass++;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (inst_valid_o === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || pc_o !== 32'h0000_0100 || inst_o !== word_of(32'h0000_0100))
      $display("FAIL jump_valid: got found=%0b pc=%h inst=%h, expected pc=00000100 inst=%h",
               found, pc_o, inst_o, word_of(32'h0000_0100));
    else n_pass++;
  endtask

  task automatic test_jump_align_and_stall();
    @(posedge clk); #1;
    ibus_gnt_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    jump_req_i = 1'b1;
    jump_pc_i  = 32'h0000_0102;
    @(posedge clk); #1;
    jump_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0000_0100)
      $display("FAIL jump_align: got req=%0b addr=%h, expected req=1 addr=00000100", ibus_req_o, ibus_addr_o);
    else n_pass++;
    @(posedge clk); #1;
    stall_i    = 1'b1;
    jump_req_i = 1'b1;
    jump_pc_i  = 32'h0000_0800;
    @(posedge clk); #1;
    stall_i    = 1'b0;
    jump_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0000_0100)
      $display("FAIL jump_stalled: got req=%0b addr=%h, expected req=1 addr=00000100", ibus_req_o, ibus_addr_o);
    else n_pass++;
  endtask

  task automatic test_gnt_hold();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0000_0100)
        $display("FAIL gnt_wait: got req=%0b addr=%h, expected req=1 addr=00000100", ibus_req_o, ibus_addr_o);
      else n_pass++;
    end
    @(posedge clk); #1;
    jump_req_i = 1'b1;
    jump_pc_i  = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    jump_req_i = 1'b0;
    ibus_gnt_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'hFFFF_FFFC)
      $display("FAIL top_addr: got req=%0b addr=%h, expected req=1 addr=fffffffc", ibus_req_o, ibus_addr_o);
    else n_pass++;
    @(posedge clk); #1;
    ibus_gnt_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0)
      $display("FAIL wrap_addr: got req=%0b addr=%h, expected req=1 addr=00000000", ibus_req_o, ibus_addr_o);
    else n_pass++;
    @(posedge clk); #1;
    ibus_gnt_i = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    bit found;
    #1;
    stall_i = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b1)
      $display("FAIL prefill: got valid=%0b, expected 1", inst_valid_o);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (inst_valid_o !== 1'b0 || ibus_req_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== NOP_INST)
      $display("FAIL async_reset: got valid=%0b req=%0b pc=%h inst=%h, expected valid=0 req=0 pc=0 inst=%h",
               inst_valid_o, ibus_req_o, pc_o, inst_o, NOP_INST);
    else n_pass++;
    @(posedge clk); #1;
    stall_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== RESET_PC || inst_valid_o !== 1'b0)
      $display("FAIL post_reset_req: got req=%0b addr=%h valid=%0b, expected req=1 addr=%h valid=0",
               ibus_req_o, ibus_addr_o, inst_valid_o, RESET_PC);
    else n_pass++;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (inst_valid_o === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || pc_o !== RESET_PC || inst_o !== word_of(RESET_PC))
      $display("FAIL post_reset_valid: got found=%0b pc=%h inst=%h, expected pc=%h inst=%h",
               found, pc_o, inst_o, RESET_PC, word_of(RESET_PC));
    else n_pass++;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch_seq();
    test_stall();
    test_jump();
    test_jump_align_and_stall();
    test_gnt_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
